// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the core's load/store port. Accepts one request
// at a time, services it against an internal word array and returns the
// response over a second valid/ready handshake, LATENCY cycles after the
// request was presented.
// Optional build macro: MEM_ERR_EN enables misaligned / out-of-range request
// detection. Without it rsp_err is tied low and the array aliases through
// the address space.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  // Operation seen on the edge that enters RESP. With LATENCY==1 that edge is
  // the accept edge itself, so the live request fields are used in IDLE.
  logic [31:0]   op_addr_s;
  logic          op_we_s;
  logic [3:0]    op_wstrb_s;
  logic [31:0]   op_wdata_s;
  logic [AW-1:0] idx_s;
  logic          err_s;
  logic          enter_resp_s;
  logic          mem_wr_s;
  logic [31:0]   rd_word_s;

  logic [31:0] mem_q [DEPTH_WORDS];

`ifdef MEM_ERR_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  logic err_q, err_d;
`else
  logic unused_addr_s;
`endif

  // Select live request fields in IDLE, latched fields otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_addr_s  = req_addr;
      op_we_s    = req_we;
      op_wstrb_s = req_wstrb;
      op_wdata_s = req_wdata;
    end else begin
      op_addr_s  = addr_q;
      op_we_s    = we_q;
      op_wstrb_s = wstrb_q;
      op_wdata_s = wdata_q;
    end
  end

  assign idx_s     = op_addr_s[AW+1:2];
  assign rd_word_s = mem_q[idx_s];

`ifdef MEM_ERR_EN
  assign err_s   = (op_addr_s[1:0] != 2'b00) || ({1'b0, op_addr_s} >= ADDR_LIMIT);
  assign rsp_err = err_q;
`else
  // Byte offset and bits above the index field are deliberately ignored.
  assign unused_addr_s = ^{addr_q[31:AW+2], addr_q[1:0]};
  assign err_s         = 1'b0;
  assign rsp_err       = 1'b0;
`endif

  assign mem_wr_s  = enter_resp_s & op_we_s & ~err_s;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;

  // Next-state, request latching and response-data computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    enter_resp_s = 1'b0;
    req_ready    = 1'b0;
`ifdef MEM_ERR_EN
    err_d        = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wstrb_d = req_wstrb;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          if (LATENCY == 32'd1) begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Response payload is captured once, on the edge that enters RESP.
    if (enter_resp_s) begin
      if (err_s || op_we_s) begin
        rdata_d = 32'd0;
      end else begin
        rdata_d = rd_word_s;
      end
`ifdef MEM_ERR_EN
      err_d = err_s;
`endif
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and response registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wstrb_q <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef MEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Word array: no reset; byte lanes written only when their strobe is set.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (op_wstrb_s[i]) begin
          mem_q[idx_s][8*i +: 8] <= op_wdata_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=2).
// Follows the MEM_ERR_EN macro of the build for the error-path vectors.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wstrb (req_wstrb),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full transaction; entered and left 1 time unit after a rising edge.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wstrb = strb;
    req_wdata = wdata;
    check_eq({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq({tag, ".early_valid"}, {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_eq({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check_eq({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq({tag, ".valid_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wstrb = 4'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;

    // Reset for three cycles, then release.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check_eq("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst.rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst.req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Full-word store then load.
    do_req("st_full", 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'd0, 1'b0);
    do_req("ld_full", 1'b0, 32'h10, 4'b0000, 32'd0, 32'hDEADBEEF, 1'b0);

    // Single-lane store merges into the existing word.
    do_req("st_lane1", 1'b1, 32'h10, 4'b0010, 32'h0000AA00, 32'd0, 1'b0);
    do_req("ld_lane1", 1'b0, 32'h10, 4'b1111, 32'hFFFFFFFF, 32'hDEADAAEF, 1'b0);

    // Backpressure: hold rsp_ready low for 5 cycles with a second request waiting.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_wstrb = 4'd0;
    @(posedge clk); #1;
    req_we    = 1'b1;
    req_addr  = 32'h14;
    req_wstrb = 4'b1111;
    req_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp.rdata", rsp_rdata, 32'hDEADAAEF);
      check_eq("bp.req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("bp.valid_drop", {31'd0, rsp_valid}, 32'd0);
    check_eq("bp.idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("bp.accepted", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check_eq("bp.st_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("bp.st_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    do_req("bp_ld", 1'b0, 32'h14, 4'd0, 32'd0, 32'h0BADF00D, 1'b0);
    do_req("bp_ld_old", 1'b0, 32'h10, 4'd0, 32'd0, 32'hDEADAAEF, 1'b0);

    // Aliasing (default build) or error path (MEM_ERR_EN build).
    do_req("st_zero", 1'b1, 32'h0, 4'b1111, 32'h11111111, 32'd0, 1'b0);
`ifdef MEM_ERR_EN
    do_req("err_st_range", 1'b1, 32'h400, 4'b1111, 32'h55, 32'd0, 1'b1);
    do_req("err_ld_range", 1'b0, 32'h400, 4'b0000, 32'd0, 32'd0, 1'b1);
    do_req("err_ld_misal", 1'b0, 32'h2, 4'b0000, 32'd0, 32'd0, 1'b1);
    do_req("err_st_misal", 1'b1, 32'h2, 4'b1111, 32'h77777777, 32'd0, 1'b1);
    do_req("err_unchanged", 1'b0, 32'h0, 4'b0000, 32'd0, 32'h11111111, 1'b0);
`else
    do_req("alias_st", 1'b1, 32'h400, 4'b1111, 32'h55, 32'd0, 1'b0);
    do_req("alias_ld", 1'b0, 32'h0, 4'b0000, 32'd0, 32'h00000055, 1'b0);
    do_req("alias_misal", 1'b0, 32'h3, 4'b0000, 32'd0, 32'h00000055, 1'b0);
`endif

    // Reset during WAIT aborts the pending store.
    do_req("pre_st", 1'b1, 32'h20, 4'b1111, 32'hCAFEF00D, 32'd0, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wstrb = 4'b1111;
    req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("rw.in_wait", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rw.rst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    check_eq("rw.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rw.no_stale", {31'd0, rsp_valid}, 32'd0);
    do_req("rw_ld", 1'b0, 32'h20, 4'd0, 32'd0, 32'hCAFEF00D, 1'b0);

    // Reset during RESP drops the response but keeps the committed store.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wstrb = 4'b1111;
    req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("rr.in_resp", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rr.dropped", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_req("rr_ld", 1'b0, 32'h30, 4'd0, 32'd0, 32'hA5A5A5A5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
